ring_nic: RTL

- Network interface controller at the processing-element end of the ring router's PE port.
- Receives 64-bit packets from the router's PE output and buffers them for processor reads.
- Accepts processor-written packets and injects them into the router's PE input using the same send/ready handshake.
- Holds one input-channel and one output-channel buffer, each with a full flag exposed as a memory-mapped status register.

---
 rtl/ring_nic_pkg.sv | 15 +
 rtl/ring_nic_channel_buf.sv | 27 ++
 rtl/ring_nic.sv | 71 +++++++
 3 files changed

// File: rtl/ring_nic_pkg.sv
// Shared constants for the ring NIC: register map and packet field positions.
// Packets pass through untouched; the field positions document the layout and locate the vc bit.
package ring_nic_pkg;

    localparam logic [1:0] ADDR_IN_BUF   = 2'd0;
    localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'd2;
    localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;

endpackage

// File: rtl/ring_nic_channel_buf.sv
// One-entry packet register with a full flag, used for both NIC channels.
// A load always wins over a clear; callers only load while the entry is empty.
module nic_channel_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= data;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ring_nic.sv
// Ring NIC: buffers one packet in each direction between the router PE port and the processor.
// Sends are gated so a packet only leaves during the ring phase named by its vc bit.
module ring_nic
    import ring_nic_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             polarity,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    input  logic             nicEn,
    input  logic             nicWrEn,
    input  logic             net_si,
    output logic             net_ri,
    input  logic [WIDTH-1:0] net_di,
    output logic             net_so,
    input  logic             net_ro,
    output logic [WIDTH-1:0] net_do
);

    logic             rd;
    logic             wr;
    logic             in_full;
    logic             out_full;
    logic [WIDTH-1:0] in_buf;
    logic [WIDTH-1:0] out_buf;

    assign rd = nicEn && !nicWrEn;
    assign wr = nicEn && nicWrEn;

    assign net_ri = reset && !in_full;
    assign net_so = reset && out_full && net_ro && (out_buf[VC_BIT] == polarity);
    assign net_do = out_buf;

    nic_channel_buf #(.WIDTH(WIDTH)) u_in_buf (
        .clk   (clk),
        .reset (reset),
        .load  (net_si && net_ri),
        .clear (rd && (addr == ADDR_IN_BUF)),
        .data  (net_di),
        .q     (in_buf),
        .full  (in_full)
    );

    // A write that arrives while full is dropped, even if a send empties the buffer on the same edge.
    nic_channel_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk   (clk),
        .reset (reset),
        .load  (wr && (addr == ADDR_OUT_BUF) && !out_full),
        .clear (net_so),
        .data  (d_in),
        .q     (out_buf),
        .full  (out_full)
    );

    always_comb begin
        d_out = '0;
        if (reset && rd) begin
            case (addr)
                ADDR_IN_BUF:   d_out = in_buf;
                ADDR_IN_STAT:  d_out = {{(WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_STAT: d_out = {{(WIDTH-1){1'b0}}, out_full};
                default:       d_out = '0;
            endcase
        end
    end

endmodule
